// File: rtl/param_timer_if.sv
// Control and status bundle for param_timer.
// start/stop are single-cycle request strobes with no backpressure. The
// timer acts on them at the next rising edge. count/running/expired/tick are
// registered status outputs that are valid every cycle; no valid/ready pair
// is needed. state_dbg mirrors the FSM state register for observation.
interface param_timer_if #(
   parameter int WIDTH      = 6,
   parameter int PRESCALE_W = 4
);
   logic                  en;
   logic                  start;
   logic                  stop;
   logic                  mode;
   logic [WIDTH-1:0]      cmp;
   logic [PRESCALE_W-1:0] presc;
   logic [WIDTH-1:0]      count;
   logic                  running;
   logic                  expired;
   logic                  tick;
   logic [1:0]            state_dbg;

   modport master (
      output en, start, stop, mode, cmp, presc,
      input  count, running, expired, tick, state_dbg
   );

   modport slave (
      input  en, start, stop, mode, cmp, presc,
      output count, running, expired, tick, state_dbg
   );
endinterface

// File: rtl/param_timer.sv
// Prescaled up-counter timer with one-shot and periodic modes.
// A start latches cmp/presc/mode and begins counting from zero. Each
// (presc+1) enabled cycles the count steps. A step taken at count==cmp is the
// terminal step: it pulses tick in the following cycle and either ends the
// run (one-shot, DONE) or wraps the count to zero (periodic).
module param_timer #(
   parameter int WIDTH      = 6,
   parameter int PRESCALE_W = 4
) (
   input logic           clk,
   input logic           reset,
   param_timer_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                state_q, state_n;
   logic [WIDTH-1:0]      count_q, count_n;
   logic [WIDTH-1:0]      cmp_q, cmp_n;
   logic [PRESCALE_W-1:0] pcnt_q, pcnt_n;
   logic [PRESCALE_W-1:0] presc_q, presc_n;
   logic                  mode_q, mode_n;
   logic                  tick_q, tick_n;

   // Next-state logic: stop beats start, start beats counting, and counting
   // happens only in RUN with en high.
   always_comb begin
      state_n = state_q;
      count_n = count_q;
      cmp_n   = cmp_q;
      pcnt_n  = pcnt_q;
      presc_n = presc_q;
      mode_n  = mode_q;
      tick_n  = 1'b0;
      if (bus.stop && (state_q == RUN || bus.start)) begin
         // A stop paired with a start lands in IDLE without relatching.
         state_n = IDLE;
      end else if (bus.start) begin
         state_n = RUN;
         count_n = '0;
         pcnt_n  = '0;
         cmp_n   = bus.cmp;
         presc_n = bus.presc;
         mode_n  = bus.mode;
      end else if (state_q == RUN && bus.en) begin
         if (pcnt_q == presc_q) begin
            pcnt_n = '0;
            if (count_q == cmp_q) begin
               tick_n = 1'b1;
               if (mode_q) begin
                  count_n = '0;
               end else begin
                  state_n = DONE;
               end
            end else begin
               count_n = count_q + 1'b1;
            end
         end else begin
            pcnt_n = pcnt_q + 1'b1;
         end
      end
   end

   // State and datapath registers; reset overrides every request.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         count_q <= '0;
         cmp_q   <= '0;
         pcnt_q  <= '0;
         presc_q <= '0;
         mode_q  <= 1'b0;
         tick_q  <= 1'b0;
      end else begin
         state_q <= state_n;
         count_q <= count_n;
         cmp_q   <= cmp_n;
         pcnt_q  <= pcnt_n;
         presc_q <= presc_n;
         mode_q  <= mode_n;
         tick_q  <= tick_n;
      end
   end

   assign bus.count     = count_q;
   assign bus.running   = (state_q == RUN);
   assign bus.expired   = (state_q == DONE);
   assign bus.tick      = tick_q;
   assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_param_timer.sv
// Directed bench for param_timer. The driver pushes the expected
// {tick, expired, running, count} after every rising edge; the monitor pops
// and compares on the falling edge.
module tb_param_timer;
   localparam int W  = 6;
   localparam int PW = 4;
   localparam int EW = W + 3;

   logic clk;
   logic reset;

   param_timer_if #(.WIDTH(W), .PRESCALE_W(PW)) tif ();

   param_timer #(.WIDTH(W), .PRESCALE_W(PW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (tif.slave)
   );

   logic [EW-1:0] exp_q[$];
   string         tag_q[$];
   string         cur_tag;
   int            n_checks;
   int            n_fail;

   // Clock and reset.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [EW-1:0] pk(input logic t, input logic x,
                                        input logic r, input int c);
      logic [31:0] cv;
      cv = c;
      return {t, x, r, cv[W-1:0]};
   endfunction

   // Advance one edge and record what the outputs must be after it.
   task automatic cyc(input logic [EW-1:0] e);
      @(posedge clk);
      exp_q.push_back(e);
      tag_q.push_back(cur_tag);
      #1;
   endtask

   task automatic run_oneshot5();
      tif.cmp = 6'd5; tif.presc = 4'd0; tif.mode = 1'b0; tif.start = 1'b1;
      cyc(pk(0, 0, 1, 0));
      tif.start = 1'b0;
      for (int i = 1; i <= 5; i++) cyc(pk(0, 0, 1, i));
      cyc(pk(1, 1, 0, 5));
      cyc(pk(0, 1, 0, 5));
   endtask

   // Monitor / scoreboard.
   initial begin
      logic [EW-1:0] e;
      logic [EW-1:0] got;
      string         t;
      n_checks = 0;
      n_fail   = 0;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            t   = tag_q.pop_front();
            got = {tif.tick, tif.expired, tif.running, tif.count};
            n_checks++;
            if (got !== e) begin
               n_fail++;
               $display("FAIL %s: got tick=%0b exp=%0b run=%0b count=%0d, want tick=%0b exp=%0b run=%0b count=%0d",
                        t, got[W+2], got[W+1], got[W], got[W-1:0],
                        e[W+2], e[W+1], e[W], e[W-1:0]);
            end
         end
      end
   end

   // Stimulus.
   initial begin
      reset = 1'b1;
      tif.en = 1'b1; tif.start = 1'b1; tif.stop = 1'b0; tif.mode = 1'b0;
      tif.cmp = 6'd5; tif.presc = 4'd0;

      cur_tag = "reset_over_start";
      cyc(pk(0, 0, 0, 0));
      tif.start = 1'b0;
      cur_tag = "reset";
      cyc(pk(0, 0, 0, 0));
      reset = 1'b0;
      cur_tag = "idle";
      cyc(pk(0, 0, 0, 0));

      cur_tag = "oneshot5";
      run_oneshot5();
      cur_tag = "stop_in_done";
      tif.stop = 1'b1;
      cyc(pk(0, 1, 0, 5));
      tif.stop = 1'b0;
      cyc(pk(0, 1, 0, 5));

      // Periodic; latched values must survive input changes while running.
      cur_tag = "periodic";
      tif.cmp = 6'd3; tif.presc = 4'd1; tif.mode = 1'b1; tif.start = 1'b1;
      cyc(pk(0, 0, 1, 0));
      tif.start = 1'b0;
      tif.cmp = 6'd0; tif.presc = 4'd0; tif.mode = 1'b0;
      for (int p = 0; p < 2; p++) begin
         for (int k = 1; k <= 8; k++) begin
            if (k == 8) cyc(pk(1, 0, 1, 0));
            else        cyc(pk(0, 0, 1, k / 2));
         end
      end
      cur_tag = "periodic_stop";
      tif.stop = 1'b1;
      cyc(pk(0, 0, 0, 0));
      tif.stop = 1'b0;

      cur_tag = "en_freeze";
      tif.cmp = 6'd5; tif.presc = 4'd0; tif.mode = 1'b0; tif.start = 1'b1;
      cyc(pk(0, 0, 1, 0));
      tif.start = 1'b0;
      cyc(pk(0, 0, 1, 1));
      cyc(pk(0, 0, 1, 2));
      tif.en = 1'b0;
      for (int i = 0; i < 4; i++) cyc(pk(0, 0, 1, 2));
      tif.en = 1'b1;
      cyc(pk(0, 0, 1, 3));
      cyc(pk(0, 0, 1, 4));
      cyc(pk(0, 0, 1, 5));
      cyc(pk(1, 1, 0, 5));
      cyc(pk(0, 1, 0, 5));

      cur_tag = "stop_mid_run";
      tif.start = 1'b1;
      cyc(pk(0, 0, 1, 0));
      tif.start = 1'b0;
      cyc(pk(0, 0, 1, 1));
      cyc(pk(0, 0, 1, 2));
      tif.stop = 1'b1;
      cyc(pk(0, 0, 0, 2));
      tif.stop = 1'b0;
      cyc(pk(0, 0, 0, 2));
      cyc(pk(0, 0, 0, 2));
      cur_tag = "start_stop_same";
      tif.start = 1'b1; tif.stop = 1'b1;
      cyc(pk(0, 0, 0, 2));
      tif.start = 1'b0; tif.stop = 1'b0;
      cyc(pk(0, 0, 0, 2));

      // Restart on the cycle that would have been the terminal step.
      cur_tag = "restart_at_terminal";
      tif.cmp = 6'd2; tif.start = 1'b1;
      cyc(pk(0, 0, 1, 0));
      tif.start = 1'b0;
      cyc(pk(0, 0, 1, 1));
      cyc(pk(0, 0, 1, 2));
      tif.start = 1'b1;
      cyc(pk(0, 0, 1, 0));
      tif.start = 1'b0;
      cyc(pk(0, 0, 1, 1));
      cyc(pk(0, 0, 1, 2));
      cyc(pk(1, 1, 0, 2));

      cur_tag = "reset_mid_run";
      tif.cmp = 6'd5; tif.start = 1'b1;
      cyc(pk(0, 0, 1, 0));
      tif.start = 1'b0;
      for (int i = 1; i <= 4; i++) cyc(pk(0, 0, 1, i));
      reset = 1'b1;
      cyc(pk(0, 0, 0, 0));
      reset = 1'b0;
      cyc(pk(0, 0, 0, 0));
      cur_tag = "oneshot5_after_reset";
      run_oneshot5();

      cur_tag = "cmp_change_ignored";
      tif.cmp = 6'd5; tif.start = 1'b1;
      cyc(pk(0, 0, 1, 0));
      tif.start = 1'b0;
      cyc(pk(0, 0, 1, 1));
      tif.cmp = 6'd2;
      for (int i = 2; i <= 5; i++) cyc(pk(0, 0, 1, i));
      cyc(pk(1, 1, 0, 5));
      cur_tag = "cmp2_relatch";
      tif.start = 1'b1;
      cyc(pk(0, 0, 1, 0));
      tif.start = 1'b0;
      cyc(pk(0, 0, 1, 1));
      cyc(pk(0, 0, 1, 2));
      cyc(pk(1, 1, 0, 2));

      cur_tag = "tick_every_cycle";
      tif.cmp = 6'd0; tif.presc = 4'd0; tif.mode = 1'b1; tif.start = 1'b1;
      cyc(pk(0, 0, 1, 0));
      tif.start = 1'b0;
      for (int i = 0; i < 4; i++) cyc(pk(1, 0, 1, 0));

      cur_tag = "presc_max";
      tif.cmp = 6'd0; tif.presc = 4'd15; tif.mode = 1'b0; tif.start = 1'b1;
      cyc(pk(0, 0, 1, 0));
      tif.start = 1'b0;
      for (int k = 1; k <= 15; k++) cyc(pk(0, 0, 1, 0));
      cyc(pk(1, 1, 0, 0));

      cur_tag = "cmp_all_ones";
      tif.cmp = 6'd63; tif.presc = 4'd0; tif.mode = 1'b1; tif.start = 1'b1;
      cyc(pk(0, 0, 1, 0));
      tif.start = 1'b0;
      for (int i = 1; i <= 63; i++) cyc(pk(0, 0, 1, i));
      cyc(pk(1, 0, 1, 0));
      cyc(pk(0, 0, 1, 1));

      // Let the monitor drain the queue within a bounded number of cycles.
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain: got %0d pending entries, want 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
